// File: rtl/controle_posse.sv
// controle_posse: possession controller for a scoreboard -- saturating score
// keeper plus a shot-clock FSM with a fixed-length expiry buzzer pulse.
module controle_posse #(
  parameter int SHOT_LONG   = 24,
  parameter int SHOT_SHORT  = 14,
  parameter int SCORE_MAX   = 99,
  parameter int BUZZ_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] pontos,
  input  logic       sinal,
  input  logic       start,
  input  logic       pause,
  input  logic       reload24,
  input  logic       reload14,
  output logic [6:0] placar,
  output logic [6:0] tempo,
  output logic       alerta,
  output logic       buzzer,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  localparam int CW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [6:0]      tempo_q, tempo_d;
  logic [6:0]      placar_q, placar_d;
  logic            alerta_q, alerta_d;
  logic            buzzer_q, buzzer_d;
  logic [CW-1:0]   buzz_cnt_q, buzz_cnt_d;
  logic [7:0]      pts_s;
  logic [7:0]      sum_s;
  logic [7:0]      lim_s;

  // Score path: priority-select the point value, then saturate in 8 bits
  always_comb begin
    pts_s    = 8'd0;
    sum_s    = 8'd0;
    lim_s    = 8'(SCORE_MAX);
    placar_d = placar_q;
    alerta_d = alerta_q;
    if (pontos[2]) begin
      pts_s = 8'd3;
    end else if (pontos[1]) begin
      pts_s = 8'd2;
    end else if (pontos[0]) begin
      pts_s = 8'd1;
    end else begin
      pts_s = 8'd0;
    end
    sum_s = {1'b0, placar_q} + pts_s;
    if (pts_s == 8'd0) begin
      placar_d = placar_q;
    end else if (!sinal) begin
      if (sum_s > lim_s) begin
        placar_d = lim_s[6:0];
        alerta_d = 1'b1;
      end else begin
        placar_d = sum_s[6:0];
        alerta_d = 1'b0;
      end
    end else if ({1'b0, placar_q} >= pts_s) begin
      placar_d = placar_q - pts_s[6:0];
      alerta_d = 1'b0;
    end else begin
      // subtract clipped at zero: score floors, flag is left as it was
      placar_d = 7'd0;
    end
  end

  // Shot-clock next state: reload dominates tick, pause and start
  always_comb begin
    state_d    = state_q;
    tempo_d    = tempo_q;
    buzzer_d   = buzzer_q;
    buzz_cnt_d = buzz_cnt_q;
    if (buzz_cnt_q != '0) begin
      buzz_cnt_d = buzz_cnt_q - CW'(1);
    end else begin
      buzzer_d = 1'b0;
    end
    if (reload24 || reload14) begin
      tempo_d    = reload24 ? 7'(SHOT_LONG) : 7'(SHOT_SHORT);
      buzzer_d   = 1'b0;
      buzz_cnt_d = '0;
      if (state_q == ST_EXPIRED) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (tempo_q <= 7'd1) begin
              state_d    = ST_EXPIRED;
              tempo_d    = 7'd0;
              buzzer_d   = 1'b1;
              buzz_cnt_d = CW'(BUZZ_CYCLES - 1);
            end else begin
              tempo_d = tempo_q - 7'd1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tempo_q    <= 7'(SHOT_LONG);
      placar_q   <= 7'd0;
      alerta_q   <= 1'b0;
      buzzer_q   <= 1'b0;
      buzz_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tempo_q    <= tempo_d;
      placar_q   <= placar_d;
      alerta_q   <= alerta_d;
      buzzer_q   <= buzzer_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

  assign placar = placar_q;
  assign tempo  = tempo_q;
  assign alerta = alerta_q;
  assign buzzer = buzzer_q;
  assign estado = state_q;

endmodule

// File: doc/controle_posse.md
CONTROLE_POSSE -- requirements
Module: controle_posse

Interface
REQ-001 Parameter SHOT_LONG, default 24, long shot-clock reload value in seconds.
REQ-002 Parameter SHOT_SHORT, default 14, short shot-clock reload value in seconds.
REQ-003 Parameter SCORE_MAX, default 99, score ceiling.
REQ-004 Parameter BUZZ_CYCLES, default 8, buzzer pulse length in clk cycles.
REQ-005 Port clk, input, 1, single system clock; all state changes occur on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port tick, input, 1, one-cycle 1 Hz pulse, synchronous to clk.
REQ-008 Port pontos, input, 3, debounced one-cycle point pulses: bit0 = +1, bit1 = +2, bit2 = +3.
REQ-009 Port sinal, input, 1, operation select: 0 = add, 1 = subtract; sampled with pontos.
REQ-010 Port start, input, 1, one-cycle pulse that starts the shot clock.
REQ-011 Port pause, input, 1, level input; high holds the shot clock.
REQ-012 Port reload24 / reload14, input, 1 each, one-cycle pulses that reload the shot clock with SHOT_LONG or SHOT_SHORT.
REQ-013 Port placar, output, 7, unsigned binary score.
REQ-014 Port tempo, output, 7, unsigned binary shot-clock seconds.
REQ-015 Port alerta, output, 1, sticky flag: an add was clipped at SCORE_MAX.
REQ-016 Port buzzer, output, 1, high for BUZZ_CYCLES cycles on expiry.
REQ-017 Port estado, output, 2, FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED.

Function
REQ-018 All outputs SHALL be registered; each response appears on the clk edge after the causing input cycle.
REQ-019 Shot clock FSM transitions:
- IDLE -> RUN on start.
- RUN -> PAUSE when pause = 1.
- PAUSE -> RUN when pause = 0.
- RUN -> EXPIRED on a tick while tempo = 1.
REQ-020 In RUN, each tick with pause = 0 and tempo > 1 SHALL decrement tempo by 1.
REQ-021 A tick outside RUN SHALL be ignored; ticks SHALL NOT be queued.
REQ-022 On entry to EXPIRED: tempo = 0, and buzzer goes high for exactly BUZZ_CYCLES cycles starting the same edge.
REQ-023 start in RUN, PAUSE or EXPIRED SHALL be ignored.
REQ-024 Reload in any state SHALL load tempo with the selected value and clear buzzer; reload24 wins if both reload pulses coincide.
REQ-025 Reload in EXPIRED SHALL go to IDLE; reload in RUN or PAUSE SHALL keep the current state.
REQ-026 Reload coinciding with a tick SHALL win; no decrement that cycle.
REQ-027 pause = 1 in the same cycle as start SHALL go IDLE -> RUN, then RUN -> PAUSE on the next cycle.
REQ-028 Scoring SHALL be accepted in every state.
REQ-029 Multiple pontos bits in one cycle: only the highest set bit counts (3 > 2 > 1).
REQ-030 Add: placar = min(placar + p, SCORE_MAX); alerta set if placar + p > SCORE_MAX.
REQ-031 Subtract: placar = max(placar − p, 0); never sets alerta.
REQ-032 Use an 8-bit intermediate for the add/subtract; no 7-bit wrap-around.
REQ-033 alerta SHALL clear on the next unclipped score operation or on reset.
REQ-034 An unclipped add SHALL NOT change the shot clock.

Reset
REQ-035 While reset = 0, regardless of clk, outputs SHALL be: placar = 0, tempo = SHOT_LONG, alerta = 0, buzzer = 0, estado = IDLE.
REQ-036 A reset asserted mid-buzzer or mid-count SHALL abort immediately, with no residual pulse after release.
REQ-037 First state change SHALL occur on the first clk edge after reset rises.

Verification
REQ-038 Reset, start, 24 ticks -> tempo 23…1, then 0; estado = EXPIRED; buzzer high exactly 8 cycles.
REQ-039 RUN at tempo = 10, pause high for 5 ticks, then low, 1 tick -> tempo stays 10 during pause, then 9; estado RUN→PAUSE→RUN.
REQ-040 placar = 97, add +3 -> placar 99, alerta 1; then add +1 -> 99, alerta stays 1; then subtract +2 -> 97, alerta 0.
REQ-041 placar = 1, subtract +3 -> 0, alerta 0; pontos = 3'b111 in add mode -> placar 3.
REQ-042 EXPIRED with buzzer at cycle 3 of 8, reload14 -> tempo 14, buzzer 0, estado IDLE; tick + reload24 in the same cycle while in RUN -> tempo 24.
REQ-043 reset low during RUN at tempo 5 -> tempo 24, placar 0, estado IDLE asynchronously, before the next clk edge.
